// File: rtl/cpu_pkg.sv
// Shared encodings for the register bank sequencer: request opcodes and
// the 2-bit sequencer FSM state.
package cpu_pkg;

   localparam int OP_W = 2;
   localparam int ST_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2,
      OP_MOVE  = 2'd3
   } op_t;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RSP  = 2'd3
   } state_t;

endpackage

// File: rtl/onehot_decoder.sv
// Address to one-hot decoder with enable. Addresses at or above NrOfRegs
// decode to all zeros, so an out-of-range address can never select a cell.
module onehot_decoder #(
   parameter int AddrBits = 4,
   parameter int NrOfRegs = 8
) (
   input  logic [AddrBits-1:0] addr,
   input  logic                en,
   output logic [NrOfRegs-1:0] onehot
);

   // Compare the address against every cell index.
   always_comb begin
      onehot = '0;
      for (int i = 0; i < NrOfRegs; i++) begin
         onehot[i] = en && (int'(addr) == i);
      end
   end

endmodule

// File: rtl/register_bank_sequencer.sv
// Sequencer in front of a bank of tristate register cells. Takes one
// READ/WRITE/MOVE at a time and drives per-cell write enables and tristate
// disables so that at most one cell ever drives the shared read bus.
//
// Handshakes: a transfer happens on a rising Clock edge where valid, ready
// and Tick are all 1. The producer holds valid and its payload until that
// edge; ready never depends combinationally on valid.
module register_bank_sequencer
   import cpu_pkg::*;
#(
   parameter int NrOfBits = 8,
   parameter int NrOfRegs = 8,
   parameter int AddrBits = 4
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Tick,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_op,
   input  logic [AddrBits-1:0] req_src,
   input  logic [AddrBits-1:0] req_dst,
   input  logic [NrOfBits-1:0] req_data,
   output logic [NrOfBits-1:0] wr_bus,
   output logic [NrOfRegs-1:0] we,
   output logic [NrOfRegs-1:0] cs,
   input  logic [NrOfBits-1:0] rd_bus,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [NrOfBits-1:0] rsp_data,
   output logic                err,
   output logic [ST_W-1:0]     dbg_state
);

   state_t                state;
   state_t                state_nxt;
   logic [AddrBits-1:0]   src_q;
   logic [AddrBits-1:0]   dst_q;
   logic [NrOfBits-1:0]   data_q;
   logic                  is_move_q;
   logic                  err_q;
   logic                  accept;
   logic                  src_ok;
   logic                  dst_ok;
   logic                  req_legal;
   logic                  we_en;
   logic                  cs_en;
   logic [NrOfRegs-1:0]   cs_sel;
   op_t                   op;

   assign op     = op_t'(req_op);
   assign accept = req_valid && req_ready && Tick;
   assign src_ok = int'(req_src) < NrOfRegs;
   assign dst_ok = int'(req_dst) < NrOfRegs;

   // A request is legal when every address field its op uses is in range.
   always_comb begin
      req_legal = 1'b1;
      case (op)
         OP_READ:  req_legal = src_ok;
         OP_WRITE: req_legal = dst_ok;
         OP_MOVE:  req_legal = src_ok && dst_ok;
         default:  req_legal = 1'b1;
      endcase
   end

   // State register; Tick low freezes the sequence.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= ST_IDLE;
      end else if (Tick) begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept && req_legal) begin
               case (op)
                  OP_READ:  state_nxt = ST_RD;
                  OP_WRITE: state_nxt = ST_WR;
                  OP_MOVE:  state_nxt = ST_RD;
                  default:  state_nxt = ST_IDLE;
               endcase
            end
         end
         ST_RD:   state_nxt = is_move_q ? ST_WR : ST_RSP;
         ST_WR:   state_nxt = ST_IDLE;
         ST_RSP:  state_nxt = rsp_ready ? ST_IDLE : ST_RSP;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output decode of the state register.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      we_en     = 1'b0;
      cs_en     = 1'b0;
      case (state)
         ST_IDLE: req_ready = 1'b1;
         ST_RD:   cs_en     = 1'b1;
         ST_WR:   we_en     = 1'b1;
         ST_RSP:  rsp_valid = 1'b1;
         default: req_ready = 1'b0;
      endcase
   end

   // Request latches, the shared data register and the reject pulse.
   // The data register holds write data for WRITE and the sampled read bus
   // for READ/MOVE; it feeds both wr_bus and rsp_data.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         src_q     <= '0;
         dst_q     <= '0;
         data_q    <= '0;
         is_move_q <= 1'b0;
         err_q     <= 1'b0;
      end else if (Tick) begin
         err_q <= accept && !req_legal;
         if (accept && req_legal) begin
            src_q     <= req_src;
            dst_q     <= req_dst;
            is_move_q <= (op == OP_MOVE);
            if (op == OP_WRITE) begin
               data_q <= req_data;
            end
         end
         if (state == ST_RD) begin
            data_q <= rd_bus;
         end
      end
   end

   onehot_decoder #(
      .AddrBits (AddrBits),
      .NrOfRegs (NrOfRegs)
   ) u_we_dec (
      .addr   (dst_q),
      .en     (we_en),
      .onehot (we)
   );

   onehot_decoder #(
      .AddrBits (AddrBits),
      .NrOfRegs (NrOfRegs)
   ) u_cs_dec (
      .addr   (src_q),
      .en     (cs_en),
      .onehot (cs_sel)
   );

   assign cs        = ~cs_sel;
   assign wr_bus    = data_q;
   assign rsp_data  = data_q;
   assign err       = err_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_register_bank_sequencer.sv
// Directed bench for register_bank_sequencer with a behavioural register
// bank on the tristate bus and queue-based scoreboards for writes, read
// responses and reject pulses.
module tb_register_bank_sequencer;

   localparam int NB = 8;
   localparam int NR = 8;
   localparam int AB = 4;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Tick;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [AB-1:0] req_src;
   logic [AB-1:0] req_dst;
   logic [NB-1:0] req_data;
   logic [NB-1:0] wr_bus;
   logic [NR-1:0] we;
   logic [NR-1:0] cs;
   logic [NB-1:0] rd_bus;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [NB-1:0] rsp_data;
   logic          err;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   logic tick_run    = 1'b0;
   logic tick_toggle = 1'b0;

   logic [NR+NB-1:0] wr_q[$];
   logic [NB-1:0]    rsp_q[$];
   logic [0:0]       err_q[$];

   logic [NB-1:0] bank [NR] = '{8'h10, 8'h11, 8'h12, 8'h13,
                                8'h14, 8'h15, 8'h16, 8'h17};

   register_bank_sequencer #(
      .NrOfBits (NB),
      .NrOfRegs (NR),
      .AddrBits (AB)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Tick      (Tick),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_src   (req_src),
      .req_dst   (req_dst),
      .req_data  (req_data),
      .wr_bus    (wr_bus),
      .we        (we),
      .cs        (cs),
      .rd_bus    (rd_bus),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset / tick ----------------
   always #5 Clock = ~Clock;

   initial begin
      Tick = 1'b0;
      forever begin
         @(posedge Clock);
         #1;
         if (tick_run) Tick = tick_toggle ? ~Tick : 1'b1;
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   // ---------------- register bank model ----------------
   always @(posedge Clock) begin
      for (int i = 0; i < NR; i++) if (we[i]) bank[i] <= wr_bus;
   end

   always_comb begin
      rd_bus = 8'hEE;
      for (int i = 0; i < NR; i++) if (!cs[i]) rd_bus = bank[i];
   end

   // ---------------- check helper ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_we"},        32'(we),        32'h00);
      chk({tag, "_cs"},        32'(cs),        32'hFF);
      chk({tag, "_wr_bus"},    32'(wr_bus),    32'h00);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_data"},  32'(rsp_data),  32'h00);
      chk({tag, "_err"},       32'(err),       32'd0);
      chk({tag, "_state"},     32'(dbg_state), 32'd0);
   endtask

   // ---------------- monitors / scoreboard ----------------
   always @(negedge Clock) begin
      if (Reset) begin
         chk("inv_cs_onehot0", 32'($onehot0(~cs)), 32'd1);
         chk("inv_we_cs_same_cell", 32'(we & ~cs), 32'd0);
         chk("inv_we_onehot0", 32'($onehot0(we)), 32'd1);
         if (Tick && we != '0) begin
            if (wr_q.size() == 0) chk("unexpected_write", 32'(we), 32'd0);
            else chk("write_we_data", 32'({we, wr_bus}), 32'(wr_q.pop_front()));
         end
         if (Tick && rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_data), 32'hFFFF);
            else chk("rsp_data", 32'(rsp_data), 32'(rsp_q.pop_front()));
         end
         if (Tick && err) begin
            if (err_q.size() == 0) chk("unexpected_err", 32'(err), 32'd0);
            else chk("err_pulse", 32'(err), 32'(err_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [1:0] op, input int src, input int dst, input logic [NB-1:0] data);
      bit done = 0;
      @(posedge Clock);
      #1;
      req_valid = 1'b1;
      req_op    = op;
      req_src   = AB'(src);
      req_dst   = AB'(dst);
      req_data  = data;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge Clock);
         if (req_ready && Tick) begin
            @(posedge Clock);
            #1;
            done = 1;
         end
      end
      req_valid = 1'b0;
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge Clock);
         if (req_ready) ok = 1;
      end
      if (!ok) chk("idle_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [NR-1:0] oh(input int i);
      logic [NR-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      Reset     = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'd0;
      req_src   = '0;
      req_dst   = '0;
      req_data  = '0;
      rsp_ready = 1'b1;

      repeat (3) @(negedge Clock);
      chk_reset_vals("rst");
      Reset = 1'b1;
      repeat (2) @(negedge Clock);
      chk_reset_vals("post_rst_no_tick");
      tick_run = 1'b1;

      // WRITE r3 = A5
      wr_q.push_back({oh(3), 8'hA5});
      send(2'd2, 0, 3, 8'hA5);
      @(negedge Clock);
      chk("wr_ready_busy", 32'(req_ready), 32'd0);
      chk("wr_we", 32'(we), 32'h08);
      chk("wr_bus", 32'(wr_bus), 32'hA5);
      @(negedge Clock);
      chk("wr_ready_back", 32'(req_ready), 32'd1);
      chk("wr_we_off", 32'(we), 32'h00);

      // READ r3 with the response held off for 5 cycles
      rsp_ready = 1'b0;
      rsp_q.push_back(8'hA5);
      send(2'd1, 3, 0, 8'h00);
      @(negedge Clock);
      chk("rd_cs", 32'(cs), 32'hF7);
      chk("rd_no_rsp_yet", 32'(rsp_valid), 32'd0);
      @(negedge Clock);
      chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rd_rsp_data", 32'(rsp_data), 32'hA5);
      chk("rd_cs_released", 32'(cs), 32'hFF);
      for (int k = 0; k < 5; k++) begin
         @(negedge Clock);
         chk("rd_hold_valid", 32'(rsp_valid), 32'd1);
         chk("rd_hold_data", 32'(rsp_data), 32'hA5);
      end
      @(posedge Clock);
      #1;
      rsp_ready = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      chk("rd_rsp_done", 32'(rsp_valid), 32'd0);

      // MOVE r3 -> r6
      wr_q.push_back({oh(6), 8'hA5});
      send(2'd3, 3, 6, 8'h00);
      @(negedge Clock);
      chk("mv_cs", 32'(cs), 32'hF7);
      chk("mv_we_idle", 32'(we), 32'h00);
      @(negedge Clock);
      chk("mv_we", 32'(we), 32'h40);
      chk("mv_wr_bus", 32'(wr_bus), 32'hA5);
      chk("mv_cs_off", 32'(cs), 32'hFF);
      wait_idle();
      rsp_q.push_back(8'hA5);
      send(2'd1, 6, 0, 8'h00);
      wait_idle();

      // Rejected requests
      err_q.push_back(1'b1);
      send(2'd2, 0, 9, 8'h3C);
      @(negedge Clock);
      chk("rej_err", 32'(err), 32'd1);
      chk("rej_we", 32'(we), 32'h00);
      chk("rej_cs", 32'(cs), 32'hFF);
      chk("rej_state", 32'(dbg_state), 32'd0);
      @(negedge Clock);
      chk("rej_err_gone", 32'(err), 32'd0);
      err_q.push_back(1'b1);
      send(2'd1, 9, 0, 8'h00);
      err_q.push_back(1'b1);
      send(2'd3, 2, 12, 8'h00);
      wait_idle();
      wait_idle();

      // MOVE r5 -> r5 writes back the same value
      wr_q.push_back({oh(5), 8'h15});
      send(2'd3, 5, 5, 8'h00);
      wait_idle();

      // NOP leaves the sequencer idle
      send(2'd0, 0, 0, 8'h00);
      @(negedge Clock);
      chk("nop_ready", 32'(req_ready), 32'd1);
      chk("nop_state", 32'(dbg_state), 32'd0);

      // MOVE r2 -> r7 with Tick toggling every cycle
      tick_toggle = 1'b1;
      wr_q.push_back({oh(7), 8'h12});
      send(2'd3, 2, 7, 8'h00);
      @(negedge Clock);
      chk("tt_rd1_cs", 32'(cs), 32'hFB);
      chk("tt_rd1_tick", 32'(Tick), 32'd0);
      @(negedge Clock);
      chk("tt_rd2_cs", 32'(cs), 32'hFB);
      chk("tt_rd2_we", 32'(we), 32'h00);
      @(negedge Clock);
      chk("tt_wr1_we", 32'(we), 32'h80);
      chk("tt_wr1_bus", 32'(wr_bus), 32'h12);
      @(negedge Clock);
      chk("tt_wr2_we", 32'(we), 32'h80);
      @(negedge Clock);
      chk("tt_done_we", 32'(we), 32'h00);
      chk("tt_done_ready", 32'(req_ready), 32'd1);
      @(posedge Clock);
      tick_toggle = 1'b0;
      repeat (2) @(negedge Clock);

      // Reset during the RD phase of MOVE r4 -> r1
      send(2'd3, 4, 1, 8'h00);
      @(negedge Clock);
      chk("ab_rd_cs", 32'(cs), 32'hEF);
      Reset = 1'b0;
      #1;
      chk_reset_vals("abort");
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      rsp_q.push_back(8'h11);
      send(2'd1, 1, 0, 8'h00);
      wait_idle();
      rsp_q.push_back(8'h12);
      send(2'd1, 7, 0, 8'h00);
      wait_idle();

      repeat (4) @(negedge Clock);
      chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
      chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
      chk("err_q_empty", 32'(err_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
